// File: rtl/hwpe_stream_package.sv
// Shared types and helpers for the HWPE-Stream traffic generator.
// LFSR step functions live here so every channel advances identically.
package hwpe_stream_package;

    typedef enum logic [1:0] {
        TG_FILE   = 2'd0,
        TG_RANDOM = 2'd1,
        TG_RAMP   = 2'd2
    } traffic_mode_t;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1,
        CH_DONE = 2'd2
    } tg_ch_state_t;

    localparam logic [31:0] TG_LFSR_POLY32 = 32'h8020_0003;
    localparam logic [15:0] TG_LFSR_POLY16 = 16'hB400;

    // Right-shifting Galois form; the polynomial constant is the tap mask.
    function automatic logic [31:0] tg_lfsr32_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ TG_LFSR_POLY32) : (v >> 1);
    endfunction

    function automatic logic [15:0] tg_lfsr16_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ TG_LFSR_POLY16) : (v >> 1);
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// HWPE-Stream point-to-point interface: valid/ready handshake with data and byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_traffic_gen_ch.sv
// One traffic-generator channel: run FSM, word counters, data/stall LFSRs and registered output.
//   state   | meaning
//   IDLE    | out of reset, no run yet
//   RUN     | emitting words until len handshakes complete
//   DONE    | run complete, eot asserted until the next start
module hwpe_stream_traffic_gen_ch
    import hwpe_stream_package::*;
#(
    parameter  int unsigned CH_ID          = 0,
    parameter  int unsigned DATA_WIDTH     = 32,
    parameter  int unsigned RESERVOIR_SIZE = 1024,
    parameter  int unsigned LEN_WIDTH      = 16,
    localparam int unsigned AW             = $clog2(RESERVOIR_SIZE),
    localparam int unsigned BE             = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  traffic_mode_t         mode_i,
    input  logic                  rand_strb_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [AW-1:0]         base_i,
    input  logic [7:0]            stall_thr_i,
    input  logic [31:0]           seed_i,
    input  logic                  force_invalid_i,
    output logic [AW-1:0]         res_addr_o,
    input  logic [DATA_WIDTH-1:0] res_data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [BE-1:0]         strb_o,
    output logic                  run_o,
    output logic                  eot_o
);

    tg_ch_state_t          state_q, state_d;
    traffic_mode_t         mode_q, mode_d;
    logic                  rand_strb_q, rand_strb_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [AW-1:0]         base_q, base_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic [15:0]           stall_q, stall_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [BE-1:0]         strb_q, strb_d;

    logic [31:0]           seed_ch, data_seed, addr_sum, strb_lo, strb_hi;
    logic [15:0]           stall_mix, stall_seed;
    logic [DATA_WIDTH-9:0] ramp_k;
    logic [DATA_WIDTH-1:0] rand_word, src_word;
    logic [BE-1:0]         rand_strb;
    logic                  hs, stall_draw;

    // A zero seed would lock a Galois LFSR, so it is replaced by 1.
    always_comb begin
        seed_ch    = seed_i ^ 32'(CH_ID);
        data_seed  = (seed_ch == '0) ? 32'h1 : seed_ch;
        stall_mix  = seed_ch[31:16] ^ seed_ch[15:0];
        stall_seed = (stall_mix == '0) ? 16'h1 : stall_mix;
    end

    assign addr_sum   = 32'(base_q) + 32'(idx_q);
    assign res_addr_o = AW'(addr_sum % RESERVOIR_SIZE);
    assign ramp_k     = (DATA_WIDTH-8)'(idx_q);

    always_comb begin
        rand_word = '0;
        for (int i = 0; i < DATA_WIDTH; i++) rand_word[i] = lfsr_q[i % 32];
        src_word = '0;
        case (mode_q)
            TG_FILE:   src_word = res_data_i;
            TG_RANDOM: src_word = rand_word;
            default:   src_word = {8'(CH_ID), ramp_k};
        endcase
    end

    // Contiguous strobe window lo..hi drawn from the same LFSR value as the data.
    always_comb begin
        strb_lo   = 32'(lfsr_q[7:0]) % BE;
        strb_hi   = strb_lo + (32'(lfsr_q[15:8]) % (BE - strb_lo));
        rand_strb = '0;
        for (int b = 0; b < BE; b++) rand_strb[b] = (32'(b) >= strb_lo) && (32'(b) <= strb_hi);
    end

    assign hs         = valid_q & ready_i;
    assign stall_draw = (stall_q[7:0] < stall_thr_i) || force_invalid_i;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        rand_strb_d = rand_strb_q;
        len_d       = len_q;
        base_d      = base_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        stall_d     = stall_q;
        valid_d     = valid_q;
        data_d      = data_q;
        strb_d      = strb_q;
        case (state_q)
            CH_IDLE, CH_DONE: begin
                if (start_i) begin
                    mode_d      = mode_i;
                    rand_strb_d = rand_strb_i;
                    len_d       = len_i;
                    base_d      = base_i;
                    idx_d       = '0;
                    cnt_d       = '0;
                    lfsr_d      = data_seed;
                    stall_d     = stall_seed;
                    state_d     = (len_i == '0) ? CH_DONE : CH_RUN;
                end
            end
            CH_RUN: begin
                stall_d = tg_lfsr16_next(stall_q);
                if (hs) begin
                    cnt_d   = cnt_q + LEN_WIDTH'(1);
                    valid_d = 1'b0;
                    if (cnt_q == len_q - LEN_WIDTH'(1)) state_d = CH_DONE;
                end
                // idx_q reaches len_q once the last word is presented, so no word follows it.
                if ((!valid_q || hs) && (idx_q != len_q) && !stall_draw) begin
                    valid_d = 1'b1;
                    data_d  = src_word;
                    strb_d  = rand_strb_q ? rand_strb : '1;
                    idx_d   = idx_q + LEN_WIDTH'(1);
                    lfsr_d  = tg_lfsr32_next(lfsr_q);
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= CH_IDLE;
            mode_q      <= TG_FILE;
            rand_strb_q <= 1'b0;
            len_q       <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            lfsr_q      <= 32'h1;
            stall_q     <= 16'h1;
            valid_q     <= 1'b0;
            data_q      <= '0;
            strb_q      <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            rand_strb_q <= rand_strb_d;
            len_q       <= len_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            stall_q     <= stall_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign strb_o  = strb_q;
    assign run_o   = (state_q == CH_RUN);
    assign eot_o   = (state_q == CH_DONE);

endmodule

// File: rtl/hwpe_stream_traffic_gen_mc.sv
// Multi-channel HWPE-Stream traffic source: NB_CH independent channels sharing one
// word reservoir, started together by a single start pulse.
module hwpe_stream_traffic_gen_mc
    import hwpe_stream_package::*;
#(
    parameter  string       STIM_FILE      = "",
    parameter  int unsigned NB_CH          = 2,
    parameter  int unsigned DATA_WIDTH     = 32,
    parameter  int unsigned RESERVOIR_SIZE = 1024,
    parameter  int unsigned LEN_WIDTH      = 16,
    localparam int unsigned AW             = $clog2(RESERVOIR_SIZE)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic                  rand_strb_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [NB_CH*AW-1:0]   base_i,
    input  logic [7:0]            stall_thr_i,
    input  logic [31:0]           seed_i,
    input  logic [NB_CH-1:0]      force_invalid_i,
    output logic                  busy_o,
    output logic [NB_CH-1:0]      eot_o,
    hwpe_stream_intf_stream.source pop_o [NB_CH-1:0]
);

    logic [DATA_WIDTH-1:0] reservoir [RESERVOIR_SIZE];
    logic [NB_CH-1:0]      run;
    logic                  start_ok;
    traffic_mode_t         mode_sel;

    // A start while any channel runs is dropped before it reaches any channel.
    assign start_ok = start_i & ~busy_o;
    assign mode_sel = (mode_i == 2'd3) ? TG_RAMP : traffic_mode_t'(mode_i);
    assign busy_o   = |run;

    for (genvar c = 0; c < NB_CH; c++) begin : g_ch
        logic [AW-1:0]           res_addr;
        logic [DATA_WIDTH-1:0]   res_data;
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] strb;
        logic                    valid;

        assign res_data = reservoir[res_addr];

        hwpe_stream_traffic_gen_ch #(
            .CH_ID          (c),
            .DATA_WIDTH     (DATA_WIDTH),
            .RESERVOIR_SIZE (RESERVOIR_SIZE),
            .LEN_WIDTH      (LEN_WIDTH)
        ) i_ch (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .start_i         (start_ok),
            .mode_i          (mode_sel),
            .rand_strb_i     (rand_strb_i),
            .len_i           (len_i),
            .base_i          (base_i[c*AW +: AW]),
            .stall_thr_i     (stall_thr_i),
            .seed_i          (seed_i),
            .force_invalid_i (force_invalid_i[c]),
            .res_addr_o      (res_addr),
            .res_data_i      (res_data),
            .ready_i         (pop_o[c].ready),
            .valid_o         (valid),
            .data_o          (data),
            .strb_o          (strb),
            .run_o           (run[c]),
            .eot_o           (eot_o[c])
        );

        assign pop_o[c].valid = valid;
        assign pop_o[c].data  = data;
        assign pop_o[c].strb  = strb;
    end

endmodule

// File: tb/tb_hwpe_stream_traffic_gen_mc.sv
// Scoreboard bench for the multi-channel traffic generator: stimulus pushes expected
// words per channel, a negedge monitor pops and compares on every handshake.
module tb_hwpe_stream_traffic_gen_mc;

    localparam int unsigned NB_CH = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned RS    = 16;
    localparam int unsigned LW    = 16;
    localparam int unsigned AW    = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        rnd;
    } exp_t;

    logic              clk_sys = 1'b0;
    logic              rst_b   = 1'b0;
    logic              start   = 1'b0;
    logic [1:0]        mode    = 2'd0;
    logic              rand_strb = 1'b0;
    logic [LW-1:0]     len     = '0;
    logic [NB_CH*AW-1:0] base  = '0;
    logic [7:0]        thr     = 8'd0;
    logic [31:0]       seed    = 32'd0;
    logic [NB_CH-1:0]  force_inv = '0;
    logic [NB_CH-1:0]  ready   = '1;
    logic              busy;
    logic [NB_CH-1:0]  eot;

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    logic [31:0] seen0[$], seen1[$], run1_0[$], run1_1[$];
    logic [31:0] res_model [RS];
    int          n_checks = 0;
    int          n_fail   = 0;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop [NB_CH-1:0] ();
    assign pop[0].ready = ready[0];
    assign pop[1].ready = ready[1];

    hwpe_stream_traffic_gen_mc #(
        .STIM_FILE      (""),
        .NB_CH          (NB_CH),
        .DATA_WIDTH     (DW),
        .RESERVOIR_SIZE (RS),
        .LEN_WIDTH      (LW)
    ) dut (
        .clk_i           (clk_sys),
        .rst_ni          (rst_b),
        .start_i         (start),
        .mode_i          (mode),
        .rand_strb_i     (rand_strb),
        .len_i           (len),
        .base_i          (base),
        .stall_thr_i     (thr),
        .seed_i          (seed),
        .force_invalid_i (force_inv),
        .busy_o          (busy),
        .eot_o           (eot),
        .pop_o           (pop)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    function automatic logic [3:0] strb_model(input logic [31:0] v);
        int lo, hi;
        logic [3:0] m;
        lo = int'(v[7:0]) % 4;
        hi = lo + int'(v[15:8]) % (4 - lo);
        m  = '0;
        for (int b = 0; b < 4; b++) if (b >= lo && b <= hi) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic strb_contig(input logic [3:0] s);
        logic [3:0] x;
        x = s;
        if (x == 4'd0) return 1'b0;
        while (!x[0]) x = x >> 1;
        return ((x & (x + 4'd1)) == 4'd0);
    endfunction

    task automatic mon_word(input int c, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word_ch%0d: got data %08h strb %0h, no word expected", c, d, s);
            return;
        end
        if (c == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        check($sformatf("data_ch%0d", c), 64'(d), 64'(e.data));
        check($sformatf("strb_ch%0d", c), 64'(s), 64'(e.strb));
        if (e.rnd) begin
            check($sformatf("strb_contig_ch%0d", c), 64'(strb_contig(s)), 64'd1);
            if (c == 0) seen0.push_back(d);
            else        seen1.push_back(d);
        end
    endtask

    always @(negedge clk_sys) begin
        if (rst_b) begin
            if (pop[0].valid && pop[0].ready) mon_word(0, pop[0].data, pop[0].strb);
            if (pop[1].valid && pop[1].ready) mon_word(1, pop[1].data, pop[1].strb);
        end
    end

    task automatic push_ramp(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q0.push_back('{data: 32'(k), strb: 4'hF, rnd: 1'b0});
            exp_q1.push_back('{data: 32'h0100_0000 | 32'(k), strb: 4'hF, rnd: 1'b0});
        end
    endtask

    task automatic push_file(input int b0, input int b1, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q0.push_back('{data: res_model[(b0 + k) % RS], strb: 4'hF, rnd: 1'b0});
            exp_q1.push_back('{data: res_model[(b1 + k) % RS], strb: 4'hF, rnd: 1'b0});
        end
    endtask

    task automatic push_rand(input logic [31:0] sd, input int n);
        logic [31:0] s0, s1;
        s0 = sd;
        s1 = sd ^ 32'd1;
        for (int k = 0; k < n; k++) begin
            exp_q0.push_back('{data: s0, strb: strb_model(s0), rnd: 1'b1});
            exp_q1.push_back('{data: s1, strb: strb_model(s1), rnd: 1'b1});
            s0 = lfsr_step(s0);
            s1 = lfsr_step(s1);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic rs, input int n,
                            input int b0, input int b1, input logic [31:0] sd);
        mode      = m;
        rand_strb = rs;
        len       = LW'(n);
        base      = {AW'(b1), AW'(b0)};
        seed      = sd;
        start     = 1'b1;
        @(posedge clk_sys); #1;
        start     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_sys); #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        while (eot !== 2'b11 && i < budget) begin
            tick();
            i++;
        end
        check(name, 64'(eot), 64'd3);
    endtask

    task automatic check_drained(input string name);
        check(name, 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < RS; i++) begin
            res_model[i]     = 32'hC0DE_0000 + 32'(i) * 32'h111;
            dut.reservoir[i] = res_model[i];
        end

        // reset values
        #12;
        check("rst_valid", 64'({pop[1].valid, pop[0].valid}), 64'd0);
        check("rst_data0", 64'(pop[0].data), 64'd0);
        check("rst_strb1", 64'(pop[1].strb), 64'd0);
        check("rst_eot",   64'(eot), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        @(negedge clk_sys) rst_b = 1'b1;
        tick();

        // len = 0: straight to DONE, no valid
        do_start(2'd2, 1'b0, 0, 0, 0, 32'd0);
        check("len0_eot_t",  64'(eot), 64'd3);
        check("len0_busy",   64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("len0_novalid", 64'({pop[1].valid, pop[0].valid}), 64'd0);
        end
        check("len0_eot_t1", 64'(eot), 64'd3);

        // RAMP len 8, back-to-back, with an ignored start mid-run
        push_ramp(8);
        do_start(2'd2, 1'b0, 8, 0, 0, 32'd0);
        check("ramp_valid_t",  64'({pop[1].valid, pop[0].valid}), 64'd0);
        check("ramp_busy_t",   64'(busy), 64'd1);
        check("ramp_eot_clr",  64'(eot), 64'd0);
        tick();
        check("ramp_valid_t1", 64'({pop[1].valid, pop[0].valid}), 64'd3);
        tick();
        tick();
        mode  = 2'd0;
        len   = LW'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("ramp_eot_t8",  64'(eot), 64'd0);
        check("ramp_busy_t8", 64'(busy), 64'd1);
        tick();
        check("ramp_eot_t9",   64'(eot), 64'd3);
        check("ramp_busy_t9",  64'(busy), 64'd0);
        check("ramp_valid_t9", 64'({pop[1].valid, pop[0].valid}), 64'd0);
        check_drained("ramp_drained");

        // FILE with wrap at the top of the reservoir
        push_file(14, 5, 4);
        do_start(2'd0, 1'b0, 4, 14, 5, 32'd0);
        wait_done("file_done", 20);
        check_drained("file_drained");

        // hold under backpressure, stall and force_invalid
        ready = 2'b00;
        push_ramp(2);
        do_start(2'd2, 1'b0, 2, 0, 0, 32'd0);
        tick();
        thr       = 8'd255;
        force_inv = 2'b11;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'({pop[1].valid, pop[0].valid}), 64'd3);
            check("hold_data0", 64'(pop[0].data), 64'h0);
            check("hold_data1", 64'(pop[1].data), 64'h0100_0000);
            check("hold_strb0", 64'(pop[0].strb), 64'hF);
            tick();
        end
        ready = 2'b11;
        tick();
        check("force_no_valid_a", 64'({pop[1].valid, pop[0].valid}), 64'd0);
        tick();
        check("force_no_valid_b", 64'({pop[1].valid, pop[0].valid}), 64'd0);
        check("force_busy", 64'(busy), 64'd1);
        force_inv = 2'b00;
        thr       = 8'd0;
        wait_done("stall_done", 20);
        check_drained("stall_drained");

        // RANDOM twice with the same seed, random strobes, moderate stalls
        thr = 8'd64;
        seen0.delete();
        seen1.delete();
        push_rand(32'h1234, 6);
        do_start(2'd1, 1'b1, 6, 0, 0, 32'h1234);
        wait_done("rand1_done", 200);
        check_drained("rand1_drained");
        check("rand1_cnt0", 64'(seen0.size()), 64'd6);
        check("rand1_cnt1", 64'(seen1.size()), 64'd6);
        if (seen0.size() > 0 && seen1.size() > 0)
            check("rand_ch_differ", 64'(seen0[0] != seen1[0]), 64'd1);
        run1_0 = seen0;
        run1_1 = seen1;
        seen0.delete();
        seen1.delete();
        push_rand(32'h1234, 6);
        do_start(2'd1, 1'b1, 6, 0, 0, 32'h1234);
        wait_done("rand2_done", 200);
        check_drained("rand2_drained");
        for (int k = 0; k < 6; k++) begin
            if (k < seen0.size() && k < run1_0.size())
                check("rand_repeat0", 64'(seen0[k]), 64'(run1_0[k]));
            if (k < seen1.size() && k < run1_1.size())
                check("rand_repeat1", 64'(seen1[k]), 64'(run1_1[k]));
        end

        // reset after 3 of 10 words, then restart from k = 0
        thr = 8'd0;
        push_ramp(3);
        do_start(2'd2, 1'b0, 10, 0, 0, 32'd0);
        repeat (4) tick();
        #1 rst_b = 1'b0;
        #1;
        check("mid_rst_valid", 64'({pop[1].valid, pop[0].valid}), 64'd0);
        check("mid_rst_data0", 64'(pop[0].data), 64'd0);
        check("mid_rst_strb0", 64'(pop[0].strb), 64'd0);
        check("mid_rst_eot",   64'(eot), 64'd0);
        check("mid_rst_busy",  64'(busy), 64'd0);
        check_drained("mid_rst_drained");
        #1 rst_b = 1'b1;
        push_ramp(3);
        do_start(2'd2, 1'b0, 3, 0, 0, 32'd0);
        wait_done("restart_done", 20);
        check_drained("restart_drained");

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_traffic_gen_mc.md
Name: hwpe_stream_traffic_gen_mc

Overview:
Multi-channel, run-time-configurable HWPE-Stream traffic source for testbenches.
- Drives NB_CH independent source streams.
- Each stream emits a programmed number of words from one of three data sources: file reservoir, LFSR-random or ramp.
- Valid-stall injection and random strobes come from seedable internal LFSRs, so runs are reproducible with no external RNG.
- Sits in unit and integration benches in front of streamers, FIFOs and HWPE engines.

Parameters:
STIM_FILE, "", hex file preloaded into reservoir; empty string disables preload.
NB_CH, 2, number of output channels (1..16).
DATA_WIDTH, 32, stream data width; multiple of 8, >=16.
RESERVOIR_SIZE, 1024, reservoir depth in words; shared, each channel has its own base offset.
LEN_WIDTH, 16, width of the per-run word-count port.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse starting a run on all channels; ignored while busy_o=1
mode_i  in  2  data source latched at start: 0 FILE, 1 RANDOM, 2 RAMP, 3 reserved (behaves as RAMP)
rand_strb_i  in  1  latched at start; 1 = random contiguous strobes, 0 = all-ones strobes
len_i  in  LEN_WIDTH  words per channel for this run, latched at start; 0 = immediate done
base_i  in  NB_CH*$clog2(RESERVOIR_SIZE)  per-channel reservoir start index, latched at start
stall_thr_i  in  8  stall probability threshold; sampled every cycle
seed_i  in  32  LFSR seed, loaded at start
force_invalid_i  in  NB_CH  per channel: suppress new valid assertions
busy_o  out  1  any channel in RUN
eot_o  out  NB_CH  per channel: run completed
pop_o  source  NB_CH  hwpe_stream_intf_stream.source array, data/strb widths from DATA_WIDTH

Behaviour:
- Reset: all pop_o data, strb and valid = 0; eot_o = 0; busy_o = 0; channel state IDLE; counters 0; LFSRs = 32'h1.
- Reset mid-run aborts the run immediately; no word is completed after reset assertion.
- Per-channel FSM:
  - IDLE -> RUN on start_i when len_i != 0.
  - IDLE -> DONE on start_i when len_i == 0.
  - RUN -> DONE on the cycle of handshake number len_i.
  - DONE -> RUN on the next start_i; eot_o clears the cycle after that start.
  - eot_o = (state == DONE).
- busy_o is the OR over channels of (state == RUN). start_i while busy_o=1 is ignored entirely, including config latching.
- Latency: start_i sampled at edge t; earliest valid on pop_o[c] is at t+1.
- Handshake rules:
  - Outputs are registered.
  - Once valid=1, data, strb and valid hold until ready=1 is sampled; stall and force_invalid_i never drop an asserted valid.
  - A new word is presented the cycle after a handshake, unless a stall is drawn.
- Stall draw: 16-bit LFSR per channel, advanced every cycle in RUN. A new valid is suppressed when lfsr[7:0] < stall_thr_i or force_invalid_i[c]=1.
  - stall_thr_i=0: never stall.
  - stall_thr_i=255: stall except when lfsr[7:0]=255.
- Data source, word index k = 0..len-1:
  - FILE: reservoir[(base_c + k) mod RESERVOIR_SIZE]; the index wraps at the top.
  - RANDOM: 32-bit Galois LFSR (poly 32'h80200003) seeded with seed_i ^ c, advanced once per presented word, replicated to fill DATA_WIDTH.
  - RAMP: {c[7:0], k[DATA_WIDTH-9:0]}; k truncates on overflow.
- Random strobe, per word from the data LFSR (BE = DATA_WIDTH/8):
  - lo = lfsr[7:0] mod BE; hi = lo + (lfsr[15:8] mod (BE-lo)).
  - strb bits lo..hi set; never all-zero.
- Word count uses a LEN_WIDTH counter; the handshake at count len-1 transitions to DONE. valid drops to 0 next cycle unless already presented and pending.
- Channels are fully independent after start; completion order is arbitrary.

Decomposition:
- hwpe_stream_package gains typedef enum logic [1:0] traffic_mode_t {TG_FILE, TG_RANDOM, TG_RAMP} and localparam TG_LFSR_POLY32.
- One sub-module, hwpe_stream_traffic_gen_ch: per-channel FSM, counters, LFSRs and output register. The top instantiates it NB_CH times and owns the shared reservoir with one read port per channel (combinational array read).

Test Plan:
- RAMP, len=8, stall_thr=0, ready tied 1 -> ch0 emits 0x00000000..0x00000007 and ch1 emits 0x01000000..0x01000007 on consecutive cycles starting t+1; eot_o=2'b11 from handshake 8 +1; busy_o falls the same cycle.
- FILE, RESERVOIR_SIZE=16, base ch0=14, len=4 -> data = res[14], res[15], res[0], res[1].
- ready held 0 for 5 cycles with stall_thr=255 and force_invalid_i=1 after valid rises -> data, strb and valid stable for all 5 cycles; the word completes when ready=1.
- RANDOM, seed=0x1234, run twice -> identical data/strb sequences per channel; ch0 differs from ch1; rand_strb_i=1 strobes always contiguous and non-zero.
- len=0 start -> eot_o=all-ones at t+1, valid never asserted; start_i pulsed during RUN -> ignored, word count unchanged.
- rst_ni asserted mid-run after 3 of 10 words -> all outputs 0 asynchronously; a new start after release restarts from k=0.
